mux4_rr_sched: RTL

Round-robin select scheduler driving the select inputs of the team's 4:1 bit multiplexer (`mux4_to_1`). It accepts four request lines, grants one channel at a time in fair rotation, and holds that selection for a programmable dwell period. A one-cycle break-before-make gap separates grants so the mux output is never re-steered mid-transfer. Downstream logic samples the mux output only while `sel_valid` is high.

---
 rtl/mux4_pkg.sv | 28 ++
 rtl/mux4_rr_sched_pick.sv | 42 ++++
 rtl/mux4_rr_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mux4_pkg.sv
// mux4_pkg -- shared definitions for the mux4_to_1 select scheduler.
//   state_t     : FSM state encoding (ST_IDLE, ST_ACTIVE, ST_GAP)
//   NCH         : number of mux channels
//   idx_to_sel  : channel index -> {s0,s1} select code
//   idx_to_onehot : channel index -> one-hot grant vector
package mux4_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // The mux decodes index = 2*s0 + s1, so {s0,s1} is just the index bits.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return idx;
  endfunction

  function automatic logic [NCH-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_pick.sv
// rr_pick4 -- combinational round-robin picker for four requesters.
//   req  [3:0] in  : request lines
//   last [1:0] in  : most recently granted channel
//   pick [1:0] out : first set request searching upward from last+1 (mod 4)
//   any        out : at least one request is set
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [1:0]     last,
  output logic [1:0]     pick,
  output logic           any
);

  // rot[k] is the request of the channel k+1 positions after last, so the
  // search becomes a fixed priority encode from rot[0] upward.
  logic [NCH-1:0] rot;
  logic [1:0]     off;
  logic           found;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_rot
      assign rot[gi] = req[last + 2'(gi + 1)];
    end
  endgenerate

  always_comb begin
    off   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && rot[k]) begin
        off   = 2'(k);
        found = 1'b1;
      end
    end
  end

  assign pick = last + 2'd1 + off;
  assign any  = |req;

endmodule

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched -- round-robin select scheduler for the mux4_to_1 multiplexer.
// Grants one channel at a time, holds it for HOLD_CYCLES cycles (or until
// release_i), then inserts a one-cycle gap before the next grant.
//   clk        in      : system clock, rising edge
//   rst_n      in      : asynchronous active-low reset
//   req  [3:0] in      : per-channel requests
//   release_i  in      : end the current grant early (ACTIVE only)
//   s0, s1     out     : mux select, index = 2*s0 + s1 (held through gaps)
//   grant[3:0] out     : one-hot grant, zero when nothing is granted
//   sel_valid  out     : mux output carries the granted channel's data
//   busy       out     : scheduler is in ACTIVE or GAP
// All outputs come straight from flops.
module mux4_rr_sched
  import mux4_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           release_i,
  output logic           s0,
  output logic           s1,
  output logic [NCH-1:0] grant,
  output logic           sel_valid,
  output logic           busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       last_reg, last_next;
  logic [1:0]       sel_reg, sel_next;
  logic [NCH-1:0]   grant_reg, grant_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;

  logic [1:0]       pick;
  logic             any;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_reg),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      last_reg  <= 2'd3;      // channel 0 wins the first search
      sel_reg   <= 2'd0;
      grant_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  // Outputs are computed for the state being entered so they register
  // alongside it; a new grant is visible right after the edge that picks it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;

    case (state_reg)
      ST_IDLE, ST_GAP: begin
        if (any) begin
          state_next = ST_ACTIVE;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
          last_next  = pick;
          sel_next   = idx_to_sel(pick);
          grant_next = idx_to_onehot(pick);
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
          grant_next = '0;
          valid_next = 1'b0;
          busy_next  = 1'b0;
        end
      end

      ST_ACTIVE: begin
        // req is not looked at here: the grant is held regardless.
        if (cnt_reg == '0 || release_i) begin
          state_next = ST_GAP;
          grant_next = '0;
          valid_next = 1'b0;
          busy_next  = 1'b1;    // select code stays put through the gap
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign s0        = sel_reg[1];
  assign s1        = sel_reg[0];
  assign grant     = grant_reg;
  assign sel_valid = valid_reg;
  assign busy      = busy_reg;

endmodule
